// File: rtl/mips_bus_arbiter_pkg.sv
// mips_bus_arbiter_pkg: arbiter state encoding and grant constants
package mips_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} arb_state_t;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;
endpackage

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter sharing one Avalon bus between fetch (m0) and load/store (m1)
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant
);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic req0, req1, own0, own1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // reset forces the idle view combinationally, even mid-transfer
  assign own0 = !reset && state_q == OWN_M0;
  assign own1 = !reset && state_q == OWN_M1;
  always_comb begin
    address = own0 ? m0_address : own1 ? m1_address : '0;
    read = own0 ? m0_read : own1 ? m1_read : 1'b0;
    write = own0 ? m0_write : own1 ? m1_write : 1'b0;
    writedata = own0 ? m0_writedata : own1 ? m1_writedata : '0;
    byteenable = own0 ? m0_byteenable : own1 ? m1_byteenable : '0;
    m0_waitrequest = own0 ? waitrequest : 1'b1;
    m1_waitrequest = own1 ? waitrequest : 1'b1;
    m0_readdata = own0 ? readdata : '0;
    m1_readdata = own1 ? readdata : '0;
    grant = own0 ? GRANT_M0 : own1 ? GRANT_M1 : GRANT_NONE;
    // last_q=1 means m1 was served last, so m0 wins a tie
    state_d = (state_q == IDLE) ? ((req0 && (!req1 || last_q)) ? OWN_M0 : req1 ? OWN_M1 : IDLE)
            : (state_q == OWN_M0) ? (!req0 ? IDLE : waitrequest ? OWN_M0 : req1 ? OWN_M1 : IDLE)
            : (state_q == OWN_M1) ? (!req1 ? IDLE : waitrequest ? OWN_M1 : req0 ? OWN_M0 : IDLE)
            : IDLE;
    last_d = (own0 && req0 && !waitrequest) ? 1'b0 : (own1 && req1 && !waitrequest) ? 1'b1 : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed cycle vectors with a queue-based scoreboard checked at negedge
module tb_mips_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata, m1_address, m1_writedata, m1_readdata;
  logic m0_read, m0_write, m0_waitrequest, m1_read, m1_write, m1_waitrequest;
  logic [3:0] m0_byteenable, m1_byteenable, byteenable;
  logic [31:0] address, writedata, readdata;
  logic read, write, waitrequest;
  logic [1:0] grant;
  typedef struct {
    string name;
    logic [137:0] v;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .grant(grant)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [137:0] act;
      e = q.pop_front();
      act = {grant, read, write, address, writedata, byteenable,
             m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got g/r/w/a/wd/be/w0/w1/d0/d1=%h/%b/%b/%h/%h/%h/%b/%b/%h/%h expected %h/%b/%b/%h/%h/%h/%b/%b/%h/%h",
                 e.name, act[137:136], act[135], act[134], act[133:102], act[101:70], act[69:66],
                 act[65], act[64], act[63:32], act[31:0],
                 e.v[137:136], e.v[135], e.v[134], e.v[133:102], e.v[101:70], e.v[69:66],
                 e.v[65], e.v[64], e.v[63:32], e.v[31:0]);
      end
    end
  end
  task automatic chk(input string n, input logic [1:0] g, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic w0, input logic w1, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.name = n;
    e.v = {g, r, w, a, wd, be, w0, w1, d0, d1};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string n);
    chk(n, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 32'h0);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    {m0_address, m0_read, m0_write, m0_writedata} = '0;
    {m1_address, m1_read, m1_write, m1_writedata} = '0;
    m0_byteenable = 4'hf;
    m1_byteenable = 4'hf;
    waitrequest = 1'b1;
    readdata = 32'h12345678;
    @(posedge clk);
    #1;
    idle("reset_0");
    idle("reset_1");
    // single m0 fetch, slave ready at first owned cycle
    reset = 1'b0;
    m0_read = 1'b1;
    m0_address = 32'hBFC00000;
    idle("fetch_arb");
    waitrequest = 1'b0;
    readdata = 32'h8C080004;
    chk("fetch_own", 2'b01, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hf, 1'b0, 1'b1, 32'h8C080004, 32'h0);
    m0_read = 1'b0;
    idle("fetch_done");
    // tie after reset: m0 first, then m1 with no idle gap
    reset = 1'b1;
    m0_read = 1'b1;
    m0_address = 32'h100;
    m1_read = 1'b1;
    m1_address = 32'h200;
    readdata = 32'hA5A5A5A5;
    idle("tie_reset");
    reset = 1'b0;
    idle("tie_arb");
    chk("tie_m0", 2'b01, 1'b1, 1'b0, 32'h100, 32'h0, 4'hf, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h0);
    m0_read = 1'b0;
    chk("tie_m1", 2'b10, 1'b1, 1'b0, 32'h200, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, 32'hA5A5A5A5);
    m1_read = 1'b0;
    idle("tie_done");
    // m1 write stalled three cycles while m0 waits
    m1_write = 1'b1;
    m1_address = 32'h00001000;
    m1_writedata = 32'hDEADBEEF;
    m1_byteenable = 4'b0011;
    waitrequest = 1'b1;
    readdata = 32'h11111111;
    idle("wr_arb");
    m0_read = 1'b1;
    m0_address = 32'h300;
    for (int i = 0; i < 3; i++)
      chk("wr_stall", 2'b10, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b1, 32'h0, 32'h11111111);
    waitrequest = 1'b0;
    chk("wr_done", 2'b10, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 32'h0, 32'h11111111);
    m1_write = 1'b0;
    m1_writedata = 32'h0;
    m1_byteenable = 4'hf;
    chk("wr_then_m0", 2'b01, 1'b1, 1'b0, 32'h300, 32'h0, 4'hf, 1'b0, 1'b1, 32'h11111111, 32'h0);
    m0_read = 1'b0;
    idle("wr_idle");
    // both continuously requesting: grants alternate each completion (m0 served last, so m1 first)
    m0_read = 1'b1;
    m0_address = 32'h500;
    m1_read = 1'b1;
    m1_address = 32'h400;
    readdata = 32'h22222222;
    idle("alt_arb");
    for (int i = 0; i < 2; i++) begin
      chk("alt_m1", 2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, 32'h22222222);
      chk("alt_m0", 2'b01, 1'b1, 1'b0, 32'h500, 32'h0, 4'hf, 1'b0, 1'b1, 32'h22222222, 32'h0);
    end
    // reset while m1 owns the bus and is stalled
    m0_read = 1'b0;
    waitrequest = 1'b1;
    chk("rst_own_m1", 2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 4'hf, 1'b1, 1'b1, 32'h0, 32'h22222222);
    reset = 1'b1;
    idle("rst_mid");
    reset = 1'b0;
    m1_read = 1'b0;
    idle("rst_after");
    // m0 abandons its read; last owner stays m1 so the next tie goes to m0
    m0_read = 1'b1;
    m0_address = 32'h600;
    idle("drop_arb");
    chk("drop_own", 2'b01, 1'b1, 1'b0, 32'h600, 32'h0, 4'hf, 1'b1, 1'b1, 32'h22222222, 32'h0);
    m0_read = 1'b0;
    chk("drop_now", 2'b01, 1'b0, 1'b0, 32'h600, 32'h0, 4'hf, 1'b1, 1'b1, 32'h22222222, 32'h0);
    m0_read = 1'b1;
    m0_address = 32'h700;
    m1_read = 1'b1;
    m1_address = 32'h800;
    idle("drop_idle");
    waitrequest = 1'b0;
    chk("drop_tie_m0", 2'b01, 1'b1, 1'b0, 32'h700, 32'h0, 4'hf, 1'b0, 1'b1, 32'h22222222, 32'h0);
    m0_read = 1'b0;
    chk("drop_tie_m1", 2'b10, 1'b1, 1'b0, 32'h800, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, 32'h22222222);
    m1_read = 1'b0;
    idle("end_idle");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
